// File: rtl/approx_error_monitor.sv
// Error monitor for the 8-bit approximate adder: checks each registered sum
// against the exact result and reports windowed error statistics.
module approx_error_monitor #(
  parameter int WINDOW = 256,
  parameter int CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_x,
  input  logic [7:0]       in_y,
  output logic [7:0]       add_x,
  output logic [7:0]       add_y,
  input  logic [8:0]       approx_sum,
  output logic             busy,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_err_cnt,
  output logic [CNT_W+8:0] rpt_dist_sum,
  output logic [8:0]       rpt_max_err
);

  localparam int DW = CNT_W + 9;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    REPORT
  } state_t;

  state_t st, st_nx;

  logic [CNT_W-1:0] smp_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [DW-1:0]    dist_sum;
  logic [8:0]       max_err;
  logic             s1_v;
  logic [7:0]       s1_x;
  logic [7:0]       s1_y;
  logic             acc;
  logic             last;
  logic             clr;
  logic [8:0]       exact;
  logic [8:0]       d;

  assign in_ready = (st == ACCUM);
  assign acc      = in_valid & in_ready;
  assign last     = (smp_cnt == CNT_W'(WINDOW - 1));

  // adder sees 0+0 whenever nothing is accepted
  assign add_x = acc ? in_x : 8'h00;
  assign add_y = acc ? in_y : 8'h00;

  always_ff @(posedge clock) begin
    if (reset) st <= IDLE;
    else       st <= st_nx;
  end

  always_comb begin
    st_nx     = st;
    busy      = 1'b0;
    rpt_valid = 1'b0;
    clr       = 1'b0;
    unique case (st)
      IDLE: begin
        if (start) begin
          st_nx = ACCUM;
          clr   = 1'b1;
        end
      end
      ACCUM: begin
        busy = 1'b1;
        if (acc && last) st_nx = DRAIN;
      end
      DRAIN: begin
        busy  = 1'b1;
        st_nx = REPORT;
      end
      REPORT: begin
        busy      = 1'b1;
        rpt_valid = 1'b1;
        if (rpt_ready) st_nx = IDLE;
      end
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_v <= 1'b0;
      s1_x <= 8'h00;
      s1_y <= 8'h00;
    end else begin
      s1_v <= acc;
      if (acc) begin
        s1_x <= in_x;
        s1_y <= in_y;
      end
    end
  end

  assign exact = {1'b0, s1_x} + {1'b0, s1_y};
  assign d     = (exact >= approx_sum) ? exact - approx_sum
                                       : approx_sum - exact;

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      smp_cnt <= '0;
    end else if (acc) begin
      smp_cnt <= smp_cnt + 1'b1;
    end
  end

  // stats are only idle in REPORT, so they double as the report
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      err_cnt  <= '0;
      dist_sum <= '0;
      max_err  <= '0;
    end else if (s1_v) begin
      err_cnt  <= err_cnt + CNT_W'(d != 9'd0);
      dist_sum <= dist_sum + DW'(d);
      if (d > max_err) max_err <= d;
    end
  end

  assign rpt_err_cnt  = err_cnt;
  assign rpt_dist_sum = dist_sum;
  assign rpt_max_err  = max_err;

endmodule

// File: tb/tb_approx_error_monitor.sv
// Directed bench for approx_error_monitor with a behavioural
// registered adder whose error pattern is selected per test.
module tb_approx_error_monitor;

  localparam int WINDOW = 256;
  localparam int CNT_W  = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_x;
  logic [7:0]       in_y;
  logic [7:0]       add_x;
  logic [7:0]       add_y;
  logic [8:0]       approx_sum = 9'd0;
  logic             busy;
  logic             rpt_valid;
  logic             rpt_ready;
  logic [CNT_W-1:0] rpt_err_cnt;
  logic [CNT_W+8:0] rpt_dist_sum;
  logic [8:0]       rpt_max_err;

  int n_chk  = 0;
  int n_fail = 0;
  int mode   = 0;

  approx_error_monitor #(
    .WINDOW(WINDOW),
    .CNT_W (CNT_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_y        (in_y),
    .add_x       (add_x),
    .add_y       (add_y),
    .approx_sum  (approx_sum),
    .busy        (busy),
    .rpt_valid   (rpt_valid),
    .rpt_ready   (rpt_ready),
    .rpt_err_cnt (rpt_err_cnt),
    .rpt_dist_sum(rpt_dist_sum),
    .rpt_max_err (rpt_max_err)
  );

  always #5 clock = ~clock;

  // 0 exact, 1 two fixed faults, 2 lower-OR adder, 3 lsb flipped
  function automatic logic [8:0] adder(input int m,
                                       input logic [7:0] a,
                                       input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (m)
      1: begin
        if (a == 8'h0F && b == 8'h01) s = 9'h011;
        else if (a == 8'hFF && b == 8'hFF) s = 9'h1F0;
      end
      2: s = {({1'b0, a[7:4]} + {1'b0, b[7:4]}
               + {4'b0, a[3] & b[3]}), a[3:0] | b[3:0]};
      3: s = s ^ 9'h001;
      default: ;
    endcase
    return s;
  endfunction

  always @(posedge clock) approx_sum <= adder(mode, add_x, add_y);

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic gen(input int kind, input int i,
                     output logic [7:0] x, output logic [7:0] y);
    logic [7:0] b;
    b = 8'(i);
    case (kind)
      1: begin
        if (i == 0)      begin x = 8'h0F; y = 8'h01; end
        else if (i == 1) begin x = 8'hFF; y = 8'hFF; end
        else             begin x = b;     y = 8'h00; end
      end
      2: begin
        x = {4'h0, b[3:0]};
        y = {4'h0, b[7:4]};
      end
      default: begin
        x = 8'(i * 7);
        y = 8'(i * 13 + 5);
      end
    endcase
  endtask

  task automatic window(input string tn, input int kind,
                        input int bub, input int hold,
                        input logic [31:0] e_err,
                        input logic [31:0] e_dist,
                        input logic [31:0] e_max);
    int cnt;
    int cyc;
    logic [7:0] x;
    logic [7:0] y;
    start = 1'b1;
    step();
    start = 1'b0;
    check({tn, "_rdy"}, 32'(in_ready), 32'd1);
    check({tn, "_busy"}, 32'(busy), 32'd1);
    cnt = 0;
    cyc = 0;
    while (cnt < WINDOW && cyc < 2000) begin
      gen(kind, cnt, x, y);
      in_x = x;
      in_y = y;
      in_valid = !(bub != 0 && cyc % 3 == 2);
      #0;
      if (in_valid && in_ready) begin
        if (cnt == 1) begin
          check({tn, "_addx"}, 32'(add_x), 32'(x));
          check({tn, "_addy"}, 32'(add_y), 32'(y));
        end
        cnt++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    in_x = 8'h00;
    in_y = 8'h00;
    check({tn, "_accepts"}, 32'(cnt), 32'(WINDOW));
    check({tn, "_drain_rdy"}, 32'(in_ready), 32'd0);
    check({tn, "_drain_rv"}, 32'(rpt_valid), 32'd0);
    step();
    check({tn, "_rv"}, 32'(rpt_valid), 32'd1);
    for (int h = 0; h < hold; h++) begin
      start = (h == 2);
      in_valid = 1'b1;
      in_x = 8'h55;
      in_y = 8'hAA;
      #0;
      check({tn, "_hold_rdy"}, 32'(in_ready), 32'd0);
      check({tn, "_hold_addx"}, 32'(add_x), 32'd0);
      step();
      check({tn, "_hold_rv"}, 32'(rpt_valid), 32'd1);
    end
    start = 1'b0;
    in_valid = 1'b0;
    in_x = 8'h00;
    in_y = 8'h00;
    check({tn, "_err"}, 32'(rpt_err_cnt), e_err);
    check({tn, "_dist"}, 32'(rpt_dist_sum), e_dist);
    check({tn, "_max"}, 32'(rpt_max_err), e_max);
    rpt_ready = 1'b1;
    step();
    rpt_ready = 1'b0;
    check({tn, "_done_rv"}, 32'(rpt_valid), 32'd0);
    check({tn, "_done_busy"}, 32'(busy), 32'd0);
    step();
    check({tn, "_idle_rdy"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    int r_err;
    int r_dist;
    int r_max;
    int ex;
    int ap;
    int dd;
    int xa;
    int ya;

    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_x = 8'h00;
    in_y = 8'h00;
    rpt_ready = 1'b0;
    repeat (3) step();
    check("rst_rdy", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rv", 32'(rpt_valid), 32'd0);
    check("rst_err", 32'(rpt_err_cnt), 32'd0);
    check("rst_dist", 32'(rpt_dist_sum), 32'd0);
    check("rst_max", 32'(rpt_max_err), 32'd0);
    reset = 1'b0;
    step();

    // abort a window after three erroneous samples
    mode = 3;
    start = 1'b1;
    step();
    start = 1'b0;
    check("abort_rdy", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_x = 8'h12;
    in_y = 8'h34;
    repeat (3) step();
    in_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_rdy0", 32'(in_ready), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rv", 32'(rpt_valid), 32'd0);
    check("abort_err", 32'(rpt_err_cnt), 32'd0);
    check("abort_dist", 32'(rpt_dist_sum), 32'd0);
    check("abort_max", 32'(rpt_max_err), 32'd0);
    step();
    check("abort_idle", 32'(in_ready), 32'd0);

    mode = 0;
    window("exact", 0, 0, 0, 32'd0, 32'd0, 32'd0);

    mode = 1;
    window("two_err", 1, 0, 0, 32'd2, 32'd15, 32'd14);

    mode = 3;
    window("bubble_hold", 0, 1, 10, 32'd256, 32'd256, 32'd1);

    r_err = 0;
    r_dist = 0;
    r_max = 0;
    for (int i = 0; i < 256; i++) begin
      xa = i % 16;
      ya = i / 16;
      ex = xa + ya;
      ap = (xa | ya) + (((xa >= 8) && (ya >= 8)) ? 16 : 0);
      dd = (ex > ap) ? ex - ap : ap - ex;
      if (dd != 0) r_err++;
      r_dist += dd;
      if (dd > r_max) r_max = dd;
    end
    mode = 2;
    window("loa_sweep", 2, 0, 0, 32'(r_err), 32'(r_dist), 32'(r_max));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
